// File: rtl/opl_timer_status.sv
// OPL2 timer control/status block: register decode for 0x02-0x04, two interval
// timers with prescalers, sticky overflow flags, status byte and IRQ line.

module opl_timer_cnt #(
  parameter int TICKS = 286
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       st,
  input  logic [7:0] init,
  output logic       ovf
);

  localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS - 1);

  logic          st_d1_q, st_d1_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ovf_q, ovf_d;

  // A start edge reloads; otherwise count while started, hold while stopped.
  always_comb begin
    st_d1_d = st;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    ovf_d   = 1'b0;
    if (st && !st_d1_q) begin
      cnt_d   = init;
      presc_d = PRESC_TOP;
    end else if (st) begin
      if (presc_q == '0) begin
        presc_d = PRESC_TOP;
        if (cnt_q == 8'hFF) begin
          cnt_d = init;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        presc_d = presc_q - PW'(1);
      end
    end else begin
      cnt_d   = cnt_q;
      presc_d = presc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_d1_q <= 1'b0;
      cnt_q   <= 8'h00;
      presc_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      st_d1_q <= st_d1_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

module opl_timer_status #(
  parameter int TIMER1_TICKS = 286,
  parameter int TIMER2_TICKS = 1145
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       irq_n
);

  logic [7:0] init1_q, init1_d, init2_q, init2_d;
  logic       mask1_q, mask1_d, mask2_q, mask2_d;
  logic       st1_q, st1_d, st2_q, st2_d;
  logic       ft1_q, ft1_d, ft2_q, ft2_d;
  logic [7:0] dout_q, dout_d;
  logic       irq_n_q, irq_n_d;
  logic       ovf1_s, ovf2_s;

  opl_timer_cnt #(.TICKS(TIMER1_TICKS)) u_t1 (
    .clk   (clk),
    .reset (reset),
    .st    (st1_q),
    .init  (init1_q),
    .ovf   (ovf1_s)
  );

  opl_timer_cnt #(.TICKS(TIMER2_TICKS)) u_t2 (
    .clk   (clk),
    .reset (reset),
    .st    (st2_q),
    .init  (init2_q),
    .ovf   (ovf2_s)
  );

  // Register decode and flag update; an overflow set overrides any clear on the
  // same edge, and the masking decision uses the mask in force before the write.
  always_comb begin
    init1_d = init1_q;
    init2_d = init2_q;
    mask1_d = mask1_q;
    mask2_d = mask2_q;
    st1_d   = st1_q;
    st2_d   = st2_q;
    ft1_d   = ft1_q;
    ft2_d   = ft2_q;
    dout_d  = dout_q;
    if (wr) begin
      case (addr)
        8'h02: init1_d = din;
        8'h03: init2_d = din;
        8'h04: begin
          if (din[7]) begin
            ft1_d = 1'b0;
            ft2_d = 1'b0;
          end else begin
            mask1_d = din[6];
            mask2_d = din[5];
            st2_d   = din[1];
            st1_d   = din[0];
            if (din[6]) ft1_d = 1'b0;
            else        ft1_d = ft1_q;
            if (din[5]) ft2_d = 1'b0;
            else        ft2_d = ft2_q;
          end
        end
        default: init1_d = init1_q;
      endcase
    end else begin
      init1_d = init1_q;
    end
    if (ovf1_s && !mask1_q) ft1_d = 1'b1;
    else                    ft1_d = ft1_d;
    if (ovf2_s && !mask2_q) ft2_d = 1'b1;
    else                    ft2_d = ft2_d;
    if (rd) dout_d = {ft1_q | ft2_q, ft1_q, ft2_q, 5'b00000};
    else    dout_d = dout_q;
    irq_n_d = ~(ft1_d | ft2_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init1_q <= 8'h00;
      init2_q <= 8'h00;
      mask1_q <= 1'b0;
      mask2_q <= 1'b0;
      st1_q   <= 1'b0;
      st2_q   <= 1'b0;
      ft1_q   <= 1'b0;
      ft2_q   <= 1'b0;
      dout_q  <= 8'h00;
      irq_n_q <= 1'b1;
    end else begin
      init1_q <= init1_d;
      init2_q <= init2_d;
      mask1_q <= mask1_d;
      mask2_q <= mask2_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      ft1_q   <= ft1_d;
      ft2_q   <= ft2_d;
      dout_q  <= dout_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign dout  = dout_q;
  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_opl_timer_status.sv
// Bench for opl_timer_status: directed scenarios plus random traffic, checked
// every cycle against an event-scheduling model of the two timers.

module tb_opl_timer_status;

  localparam int T1 = 4;
  localparam int T2 = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       irq_n;

  int total = 0;
  int bad = 0;

  // model state: edge counter and per-timer scheduled overflow edges
  int   e = 0;
  int   tk[2] = '{T1, T2};
  int   m_init[2];
  bit   m_mask[2], m_st[2], m_ft[2], m_run[2], m_ovfp[2];
  int   m_pulse[2], m_load[2];
  logic [7:0] m_dout;
  logic m_irq_n;

  opl_timer_status #(.TIMER1_TICKS(T1), .TIMER2_TICKS(T2)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .din   (din),
    .wr    (wr),
    .rd    (rd),
    .dout  (dout),
    .irq_n (irq_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %02h expected %02h", tag, e, got, exp);
    end
  endtask

  task automatic model_step(input logic w, input logic [7:0] a, input logic [7:0] d, input logic r);
    bit ovf_now[2];
    bit nft[2];
    bit st_new[2];
    bit mk_new[2];
    if (reset) begin
      for (int x = 0; x < 2; x++) begin
        m_init[x] = 0; m_mask[x] = 0; m_st[x] = 0; m_ft[x] = 0;
        m_run[x] = 0; m_ovfp[x] = 0; m_pulse[x] = -1; m_load[x] = -1;
      end
      m_dout = 8'h00;
      m_irq_n = 1'b1;
    end else begin
      for (int x = 0; x < 2; x++) begin
        ovf_now[x] = m_run[x] && (e == m_pulse[x]);
        nft[x] = m_ft[x];
        st_new[x] = m_st[x];
        mk_new[x] = m_mask[x];
      end
      if (r) m_dout = {m_ft[0] | m_ft[1], m_ft[0], m_ft[1], 5'b00000};
      if (w && a == 8'h04) begin
        if (d[7]) begin
          nft[0] = 0; nft[1] = 0;
        end else begin
          mk_new[0] = d[6]; mk_new[1] = d[5];
          st_new[0] = d[0]; st_new[1] = d[1];
          if (d[6]) nft[0] = 0;
          if (d[5]) nft[1] = 0;
        end
      end
      for (int x = 0; x < 2; x++) begin
        if (m_ovfp[x] && !m_mask[x]) nft[x] = 1;
        if (ovf_now[x]) m_pulse[x] = e + (256 - m_init[x]) * tk[x];
        if (m_load[x] == e) begin
          m_run[x] = 1;
          m_pulse[x] = e + (256 - m_init[x]) * tk[x];
          m_load[x] = -1;
        end
        if (st_new[x] && !m_st[x]) m_load[x] = e + 1;
        if (!st_new[x]) m_run[x] = 0;
        m_ft[x] = nft[x];
        m_st[x] = st_new[x];
        m_mask[x] = mk_new[x];
        m_ovfp[x] = ovf_now[x];
      end
      if (w && a == 8'h02) m_init[0] = int'(d);
      if (w && a == 8'h03) m_init[1] = int'(d);
      m_irq_n = !(m_ft[0] | m_ft[1]);
    end
  endtask

  // one clock: drive at negedge, advance model at posedge, compare #1 later
  task automatic tick(input logic w, input logic [7:0] a, input logic [7:0] d, input logic r);
    wr = w; addr = a; din = d; rd = r;
    @(posedge clk);
    e++;
    model_step(w, a, d, r);
    #1;
    check("irq_n", {7'd0, irq_n}, {7'd0, m_irq_n});
    check("dout", dout, m_dout);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic idle_to(input int target);
    while (e < target) tick(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    int w_edge;
    logic       rw, rr;
    logic [7:0] ra, rdat;
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    check("reset_dout", dout, 8'h00);
    check("reset_irq", {7'd0, irq_n}, 8'h01);
    idle(10000);

    // timer 1 basic run, 4 increments of 4 cycles
    tick(1'b1, 8'h02, 8'hFC, 1'b0);
    tick(1'b1, 8'h04, 8'h01, 1'b0);
    w_edge = e;
    idle_to(w_edge + 17);
    check("t1_pre_rise", {7'd0, irq_n}, 8'h01);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    check("t1_rise", {7'd0, irq_n}, 8'h00);
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    check("t1_status", dout, 8'hC0);
    tick(1'b1, 8'h04, 8'h80, 1'b0);
    check("irq_reset", {7'd0, irq_n}, 8'h01);
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    check("irq_reset_dout", dout, 8'h00);
    idle_to(w_edge + 33);
    check("t1_second_pre", {7'd0, irq_n}, 8'h01);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    check("t1_second", {7'd0, irq_n}, 8'h00);

    // masked overflows are discarded, unmasking lets the next one through
    tick(1'b1, 8'h04, 8'h41, 1'b0);
    idle(100);
    check("masked", {7'd0, irq_n}, 8'h01);
    tick(1'b1, 8'h04, 8'h01, 1'b0);
    idle(20);
    check("unmasked", {7'd0, irq_n}, 8'h00);

    // IRQ reset on the very edge the flag is being set
    tick(1'b1, 8'h04, 8'h80, 1'b0);
    for (int i = 0; i < 40 && !m_ovfp[0]; i++) tick(1'b0, 8'h00, 8'h00, 1'b0);
    tick(1'b1, 8'h04, 8'h80, 1'b0);
    check("set_wins", {7'd0, irq_n}, 8'h00);

    // timer 2 alone
    tick(1'b1, 8'h04, 8'h00, 1'b0);
    idle(3);
    tick(1'b1, 8'h04, 8'h80, 1'b0);
    tick(1'b1, 8'h03, 8'hFE, 1'b0);
    tick(1'b1, 8'h04, 8'h02, 1'b0);
    w_edge = e;
    idle_to(w_edge + 33);
    check("t2_pre_rise", {7'd0, irq_n}, 8'h01);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    check("t2_rise", {7'd0, irq_n}, 8'h00);
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    check("t2_status", dout, 8'hA0);

    // stop mid-count, restart reloads from init rather than resuming
    tick(1'b1, 8'h04, 8'h80, 1'b0);
    tick(1'b1, 8'h04, 8'h01, 1'b0);
    idle(7);
    tick(1'b1, 8'h04, 8'h00, 1'b0);
    idle(100);
    check("stopped", {7'd0, irq_n}, 8'h01);
    tick(1'b1, 8'h02, 8'hF0, 1'b0);
    tick(1'b1, 8'h04, 8'h01, 1'b0);
    w_edge = e;
    idle_to(w_edge + 65);
    check("restart_pre", {7'd0, irq_n}, 8'h01);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    check("restart_rise", {7'd0, irq_n}, 8'h00);

    // random register traffic
    for (int i = 0; i < 30000; i++) begin
      rw = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: ra = 8'h02;
        1: ra = 8'h03;
        2: ra = 8'h04;
        default: ra = 8'($urandom);
      endcase
      if (ra == 8'h04) begin
        rdat = 8'($urandom);
        rdat[7] = ($urandom_range(0, 3) == 0);
        rdat[6] = ($urandom_range(0, 3) == 0);
        rdat[5] = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 7) == 0) begin
        rdat = 8'($urandom);
      end else begin
        rdat = 8'($urandom_range(8'hE0, 8'hFF));
      end
      reset = ($urandom_range(0, 2999) == 0);
      tick(rw, ra, rdat, rr);
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
